// File: rtl/bus_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle bus control sequencer:
// FSM states, MIPS opcode/funct/rt fields, instruction classes, reg_we codes.
package bus_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_MULDIV,
      ST_WB,
      ST_HALT
   } state_e;

   typedef enum logic [3:0] {
      CL_ALU,
      CL_LOAD,
      CL_LWL,
      CL_LWR,
      CL_STORE,
      CL_BRANCH,
      CL_LINKBR,
      CL_J,
      CL_JAL,
      CL_JR,
      CL_JALR,
      CL_MULDIV,
      CL_MTHI,
      CL_MTLO,
      CL_MFHI,
      CL_MFLO
   } iclass_e;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_LB     = 6'h20;
   localparam logic [5:0] OP_LH     = 6'h21;
   localparam logic [5:0] OP_LWL    = 6'h22;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_LBU    = 6'h24;
   localparam logic [5:0] OP_LHU    = 6'h25;
   localparam logic [5:0] OP_LWR    = 6'h26;
   localparam logic [5:0] OP_SB     = 6'h28;
   localparam logic [5:0] OP_SH     = 6'h29;
   localparam logic [5:0] OP_SWL    = 6'h2A;
   localparam logic [5:0] OP_SW     = 6'h2B;
   localparam logic [5:0] OP_SWR    = 6'h2E;

   localparam logic [5:0] FN_JR     = 6'h08;
   localparam logic [5:0] FN_JALR   = 6'h09;
   localparam logic [5:0] FN_MFHI   = 6'h10;
   localparam logic [5:0] FN_MTHI   = 6'h11;
   localparam logic [5:0] FN_MFLO   = 6'h12;
   localparam logic [5:0] FN_MTLO   = 6'h13;
   localparam logic [5:0] FN_MULT   = 6'h18;
   localparam logic [5:0] FN_MULTU  = 6'h19;
   localparam logic [5:0] FN_DIV    = 6'h1A;
   localparam logic [5:0] FN_DIVU   = 6'h1B;

   localparam logic [4:0] RT_BLTZAL = 5'h10;
   localparam logic [4:0] RT_BGEZAL = 5'h11;

   localparam logic [1:0] REG_WE_NONE = 2'b00;
   localparam logic [1:0] REG_WE_LWL  = 2'b01;
   localparam logic [1:0] REG_WE_LWR  = 2'b10;
   localparam logic [1:0] REG_WE_FULL = 2'b11;

   function automatic logic is_load(iclass_e c);
      return (c == CL_LOAD) || (c == CL_LWL) || (c == CL_LWR);
   endfunction

   function automatic logic is_jump(iclass_e c);
      return (c == CL_J) || (c == CL_JAL) || (c == CL_JR) || (c == CL_JALR);
   endfunction

   function automatic logic is_branch(iclass_e c);
      return (c == CL_BRANCH) || (c == CL_LINKBR);
   endfunction

   function automatic logic [1:0] reg_we_of(iclass_e c);
      case (c)
         CL_ALU, CL_LOAD, CL_JAL, CL_JALR,
         CL_LINKBR, CL_MFHI, CL_MFLO: return REG_WE_FULL;
         CL_LWL:                      return REG_WE_LWL;
         CL_LWR:                      return REG_WE_LWR;
         default:                     return REG_WE_NONE;
      endcase
   endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational instruction classifier; anything unrecognised is treated as
// a plain ALU operation.
module instr_class_decode
   import bus_ctrl_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   input  logic [4:0] rt_i,
   output iclass_e    iclass_o
);

   always_comb begin
      iclass_o = CL_ALU;
      case (opcode_i)
         OP_RTYPE: begin
            case (funct_i)
               FN_JR:   iclass_o = CL_JR;
               FN_JALR: iclass_o = CL_JALR;
               FN_MFHI: iclass_o = CL_MFHI;
               FN_MTHI: iclass_o = CL_MTHI;
               FN_MFLO: iclass_o = CL_MFLO;
               FN_MTLO: iclass_o = CL_MTLO;
               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: iclass_o = CL_MULDIV;
               default: iclass_o = CL_ALU;
            endcase
         end
         OP_REGIMM: iclass_o = ((rt_i == RT_BLTZAL) || (rt_i == RT_BGEZAL)) ? CL_LINKBR : CL_BRANCH;
         OP_J:      iclass_o = CL_J;
         OP_JAL:    iclass_o = CL_JAL;
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: iclass_o = CL_BRANCH;
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: iclass_o = CL_LOAD;
         OP_LWL:    iclass_o = CL_LWL;
         OP_LWR:    iclass_o = CL_LWR;
         OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: iclass_o = CL_STORE;
         default:   iclass_o = CL_ALU;
      endcase
   end

endmodule

// File: rtl/bus_control_fsm.sv
// Multi-cycle control sequencer for the bus-interfaced MIPS core: fetch,
// decode, execute, optional memory or mul/div phase, then writeback.
module bus_control_fsm
   import bus_ctrl_pkg::*;
#(
   parameter int MULDIV_CYCLES = 32,
   parameter int WAIT_LIMIT    = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       waitrequest,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic [4:0] rt,
   input  logic       branch_taken,
   input  logic       target_is_zero,
   output logic       active,
   output logic       bus_error,
   output logic       mem_read,
   output logic       mem_write,
   output logic       instr_fetch,
   output logic       ir_we,
   output logic       pc_we,
   output logic       pc_src,
   output logic       target_we,
   output logic [1:0] reg_we,
   output logic       hi_we,
   output logic       lo_we,
   output logic       muldiv_start,
   output logic       delay_slot
);

   localparam int CNT_MAX = ((WAIT_LIMIT + 1) > (MULDIV_CYCLES + 1)) ? (WAIT_LIMIT + 1)
                                                                     : (MULDIV_CYCLES + 1);
   localparam int CNT_W = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_LIMIT - 1);
   localparam logic [CNT_W-1:0] MD_LAST   = CNT_W'(MULDIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_e           state_q;
   iclass_e          iclass_q;
   logic [CNT_W-1:0] cnt_q;
   logic             pending_q;
   logic             halt_pend_q;
   logic             delay_slot_q;
   logic             bus_error_q;

   iclass_e dec_class;
   logic    redirect;
   logic    in_wb;

   instr_class_decode u_decode (
      .opcode_i (opcode),
      .funct_i  (funct),
      .rt_i     (rt),
      .iclass_o (dec_class)
   );

   // Only meaningful in EXEC, where branch_taken is valid.
   assign redirect = is_jump(iclass_q) || (is_branch(iclass_q) && branch_taken);
   assign in_wb    = (state_q == ST_WB);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_FETCH;
         iclass_q     <= CL_ALU;
         cnt_q        <= '0;
         pending_q    <= 1'b0;
         halt_pend_q  <= 1'b0;
         delay_slot_q <= 1'b0;
         bus_error_q  <= 1'b0;
      end else begin
         unique case (state_q)
            ST_FETCH, ST_MEM: begin
               // cnt_q counts consecutive stalls of the current bus access.
               if (!waitrequest) begin
                  cnt_q   <= '0;
                  state_q <= (state_q == ST_FETCH) ? ST_DECODE : ST_WB;
               end else if (cnt_q == WAIT_LAST) begin
                  cnt_q       <= '0;
                  bus_error_q <= 1'b1;
                  state_q     <= ST_HALT;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            ST_DECODE: begin
               iclass_q <= dec_class;
               state_q  <= ST_EXEC;
            end
            ST_EXEC: begin
               if (redirect) begin
                  pending_q   <= 1'b1;
                  halt_pend_q <= target_is_zero;
               end
               if (is_load(iclass_q) || (iclass_q == CL_STORE)) begin
                  state_q <= ST_MEM;
               end else if (iclass_q == CL_MULDIV) begin
                  cnt_q   <= MD_LAST;
                  state_q <= ST_MULDIV;
               end else begin
                  state_q <= ST_WB;
               end
            end
            ST_MULDIV: begin
               if (cnt_q == '0) begin
                  state_q <= ST_WB;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            ST_WB: begin
               // The delay-slot instruction retires the saved target; the
               // redirecting instruction itself only arms the slot.
               cnt_q <= '0;
               if (delay_slot_q) begin
                  delay_slot_q <= 1'b0;
                  pending_q    <= 1'b0;
                  halt_pend_q  <= 1'b0;
                  state_q      <= halt_pend_q ? ST_HALT : ST_FETCH;
               end else begin
                  delay_slot_q <= pending_q;
                  state_q      <= ST_FETCH;
               end
            end
            ST_HALT: state_q <= ST_HALT;
            default: state_q <= ST_HALT;
         endcase
      end
   end

   // Reset parks the FSM in FETCH, so the fetch strobes are masked while it is held.
   assign active       = (state_q != ST_HALT);
   assign bus_error    = bus_error_q;
   assign instr_fetch  = reset && (state_q == ST_FETCH);
   assign mem_read     = reset && ((state_q == ST_FETCH) ||
                                   ((state_q == ST_MEM) && is_load(iclass_q)));
   assign mem_write    = (state_q == ST_MEM) && (iclass_q == CL_STORE);
   assign ir_we        = (state_q == ST_DECODE);
   assign target_we    = (state_q == ST_EXEC) && redirect;
   assign muldiv_start = (state_q == ST_EXEC) && (iclass_q == CL_MULDIV);
   assign pc_we        = in_wb;
   assign pc_src       = in_wb && delay_slot_q;
   assign reg_we       = in_wb ? reg_we_of(iclass_q) : REG_WE_NONE;
   assign hi_we        = in_wb && ((iclass_q == CL_MULDIV) || (iclass_q == CL_MTHI));
   assign lo_we        = in_wb && ((iclass_q == CL_MULDIV) || (iclass_q == CL_MTLO));
   assign delay_slot   = delay_slot_q;

endmodule

// File: tb/tb_bus_control_fsm.sv
// Directed bench for bus_control_fsm: an instruction-level schedule model
// expands each instruction into expected per-cycle outputs.
module tb_bus_control_fsm;

   localparam int MD = 4;
   localparam int WL = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       waitrequest = 1'b0;
   logic [5:0] opcode = 6'h00;
   logic [5:0] funct = 6'h00;
   logic [4:0] rt = 5'h00;
   logic       branch_taken = 1'b0;
   logic       target_is_zero = 1'b0;

   logic       active, bus_error, mem_read, mem_write, instr_fetch, ir_we;
   logic       pc_we, pc_src, target_we, hi_we, lo_we, muldiv_start, delay_slot;
   logic [1:0] reg_we;

   bus_control_fsm #(.MULDIV_CYCLES(MD), .WAIT_LIMIT(WL)) dut (
      .clk            (clk),
      .reset          (reset),
      .waitrequest    (waitrequest),
      .opcode         (opcode),
      .funct          (funct),
      .rt             (rt),
      .branch_taken   (branch_taken),
      .target_is_zero (target_is_zero),
      .active         (active),
      .bus_error      (bus_error),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .instr_fetch    (instr_fetch),
      .ir_we          (ir_we),
      .pc_we          (pc_we),
      .pc_src         (pc_src),
      .target_we      (target_we),
      .reg_we         (reg_we),
      .hi_we          (hi_we),
      .lo_we          (lo_we),
      .muldiv_start   (muldiv_start),
      .delay_slot     (delay_slot)
   );

   always #5 clk = ~clk;

   // {active, bus_error, mem_read, mem_write, instr_fetch, ir_we, pc_we, pc_src,
   //  target_we, reg_we[1:0], hi_we, lo_we, muldiv_start, delay_slot}
   logic [14:0] dut_vec;
   assign dut_vec = {active, bus_error, mem_read, mem_write, instr_fetch, ir_we, pc_we,
                     pc_src, target_we, reg_we, hi_we, lo_we, muldiv_start, delay_slot};

   localparam logic [14:0] RST_V   = 15'b100000000000000;
   localparam logic [14:0] FETCH_V = 15'b101010000000000;
   localparam logic [14:0] IRWE_V  = 15'b100001000000000;
   localparam logic [14:0] MEMRD_V = 15'b101000000000000;
   localparam logic [14:0] WB_V    = 15'b100000100110000;
   localparam logic [14:0] TWE_V   = 15'b100000001000000;
   localparam logic [14:0] DSWB_V  = 15'b100000110110001;
   localparam logic [14:0] MDS_V   = 15'b100000000000010;
   localparam logic [14:0] MULWB_V = 15'b100000100001100;
   localparam logic [14:0] HALT_V  = 15'b000000000000000;
   localparam logic [14:0] BERR_V  = 15'b010000000000000;

   bit          q_rst[$];
   logic        q_wr[$];
   logic [5:0]  q_op[$];
   logic [5:0]  q_fn[$];
   logic [4:0]  q_rt[$];
   logic        q_bt[$];
   logic        q_tz[$];
   logic [14:0] q_exp[$];

   int          lit_idx[$];
   logic [14:0] lit_vec[$];
   string       lit_name[$];

   bit m_ds, m_hp, m_halted, m_berr;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [1:0] rw;
      logic       hi, lo, ld, st, md, jmp, br;
   } attr_t;

   // Architectural effect of each instruction, straight from the ISA tables.
   function automatic attr_t attr_of(logic [5:0] op, logic [5:0] fn, logic [4:0] r);
      attr_t a;
      a = '0;
      a.rw = 2'b11;
      case (op)
         6'h00: begin
            case (fn)
               6'h08: begin a.jmp = 1'b1; a.rw = 2'b00; end
               6'h09: a.jmp = 1'b1;
               6'h11: begin a.hi = 1'b1; a.rw = 2'b00; end
               6'h13: begin a.lo = 1'b1; a.rw = 2'b00; end
               6'h18, 6'h19, 6'h1A, 6'h1B: begin
                  a.md = 1'b1; a.hi = 1'b1; a.lo = 1'b1; a.rw = 2'b00;
               end
               default: ;
            endcase
         end
         6'h01: begin a.br = 1'b1; if (r != 5'h10 && r != 5'h11) a.rw = 2'b00; end
         6'h02: begin a.jmp = 1'b1; a.rw = 2'b00; end
         6'h03: a.jmp = 1'b1;
         6'h04, 6'h05, 6'h06, 6'h07: begin a.br = 1'b1; a.rw = 2'b00; end
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: a.ld = 1'b1;
         6'h22: begin a.ld = 1'b1; a.rw = 2'b01; end
         6'h26: begin a.ld = 1'b1; a.rw = 2'b10; end
         6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: begin a.st = 1'b1; a.rw = 2'b00; end
         default: ;
      endcase
      return a;
   endfunction

   // ctl = {mr, mw, ifetch, irwe, pcwe, pcsrc, twe, rw[1:0], hi, lo, mds}
   function automatic logic [14:0] vec(logic [11:0] ctl);
      return {~m_halted, m_berr, ctl, m_ds};
   endfunction

   task automatic push(input bit rst, input logic wr, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] r, input logic bt, input logic tz, input logic [14:0] e);
      q_rst.push_back(rst); q_wr.push_back(wr); q_op.push_back(op); q_fn.push_back(fn);
      q_rt.push_back(r); q_bt.push_back(bt); q_tz.push_back(tz); q_exp.push_back(e);
   endtask

   task automatic lit(input int idx, input logic [14:0] v, input string nm);
      lit_idx.push_back(idx); lit_vec.push_back(v); lit_name.push_back(nm);
   endtask

   task automatic add_reset();
      m_ds = 1'b0; m_hp = 1'b0; m_halted = 1'b0; m_berr = 1'b0;
      push(1'b1, 1'b0, 6'h00, 6'h00, 5'h00, 1'b0, 1'b0, vec(12'b0));
   endtask

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++) push(1'b0, 1'b0, 6'h00, 6'h00, 5'h00, 1'b0, 1'b0, vec(12'b0));
   endtask

   task automatic add_stall(input int n);
      for (int i = 0; i < n; i++)
         push(1'b0, 1'b1, 6'h00, 6'h00, 5'h00, 1'b0, 1'b0, vec(12'b101000000000));
   endtask

   // fw/mw: stall cycles in the fetch / memory access; WL or more means timeout.
   task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r,
                            input int fw, input int mw, input logic bt, input logic tz);
      attr_t a;
      logic  redir;
      a = attr_of(op, fn, r);
      redir = a.jmp || (a.br && bt);
      for (int i = 0; i < fw && i < WL; i++)
         push(1'b0, 1'b1, op, fn, r, 1'b0, 1'b0, vec(12'b101000000000));
      if (fw >= WL) begin m_halted = 1'b1; m_berr = 1'b1; return; end
      push(1'b0, 1'b0, op, fn, r, 1'b0, 1'b0, vec(12'b101000000000));
      push(1'b0, 1'b0, op, fn, r, 1'b0, 1'b0, vec(12'b000100000000));
      push(1'b0, 1'b0, op, fn, r, bt, tz, vec({6'b0, redir, 4'b0, a.md}));
      if (a.ld || a.st) begin
         for (int i = 0; i < mw && i < WL; i++)
            push(1'b0, 1'b1, op, fn, r, 1'b0, 1'b0, vec({a.ld, a.st, 10'b0}));
         if (mw >= WL) begin m_halted = 1'b1; m_berr = 1'b1; return; end
         push(1'b0, 1'b0, op, fn, r, 1'b0, 1'b0, vec({a.ld, a.st, 10'b0}));
      end
      if (a.md) for (int i = 0; i < MD; i++) push(1'b0, 1'b0, op, fn, r, 1'b0, 1'b0, vec(12'b0));
      push(1'b0, 1'b0, op, fn, r, 1'b0, 1'b0,
           vec({4'b0, 1'b1, m_ds, 1'b0, a.rw, a.hi, a.lo, 1'b0}));
      if (m_ds) begin
         m_ds = 1'b0;
         if (m_hp) m_halted = 1'b1;
         m_hp = 1'b0;
      end else if (redir) begin
         m_ds = 1'b1;
         m_hp = tz;
      end
   endtask

   task automatic build();
      int s;
      add_reset();                                   lit(0, RST_V, "reset_state");
      s = q_exp.size();
      add_instr(6'h00, 6'h21, 5'h00, 0, 0, 1'b0, 1'b0);  // ADDU
      lit(s, FETCH_V, "addu_fetch"); lit(s + 3, WB_V, "addu_wb"); lit(s + 4, FETCH_V, "addu_next_fetch");
      s = q_exp.size();
      add_instr(6'h23, 6'h00, 5'h00, 3, 2, 1'b0, 1'b0);  // LW, waits in fetch and mem
      lit(s + 4, IRWE_V, "lw_irwe"); lit(s + 6, MEMRD_V, "lw_mem"); lit(s + 9, WB_V, "lw_wb_cycle10");
      s = q_exp.size();
      add_instr(6'h04, 6'h00, 5'h00, 0, 0, 1'b1, 1'b0);  // BEQ taken
      lit(s + 2, TWE_V, "beq_target_we");
      s = q_exp.size();
      add_instr(6'h00, 6'h21, 5'h00, 0, 0, 1'b0, 1'b0);  // ADDU in delay slot
      lit(s + 3, DSWB_V, "delay_slot_wb");
      s = q_exp.size();
      add_instr(6'h00, 6'h21, 5'h00, 0, 0, 1'b0, 1'b0);
      lit(s, FETCH_V, "after_slot_fetch");
      s = q_exp.size();
      add_instr(6'h00, 6'h18, 5'h00, 0, 0, 1'b0, 1'b0);  // MULT
      lit(s + 2, MDS_V, "mult_start"); lit(s + 7, MULWB_V, "mult_wb");
      add_instr(6'h2B, 6'h00, 5'h00, WL - 1, WL - 1, 1'b0, 1'b0);  // SW, longest tolerated stalls
      add_instr(6'h22, 6'h00, 5'h00, 0, 1, 1'b0, 1'b0);  // LWL
      add_instr(6'h26, 6'h00, 5'h00, 1, 0, 1'b0, 1'b0);  // LWR
      add_instr(6'h00, 6'h11, 5'h00, 0, 0, 1'b0, 1'b0);  // MTHI
      add_instr(6'h00, 6'h13, 5'h00, 0, 0, 1'b0, 1'b0);  // MTLO
      add_instr(6'h00, 6'h10, 5'h00, 0, 0, 1'b0, 1'b0);  // MFHI
      add_instr(6'h00, 6'h1B, 5'h00, 0, 0, 1'b0, 1'b0);  // DIVU
      add_instr(6'h01, 6'h00, 5'h11, 0, 0, 1'b0, 1'b1);  // BGEZAL not taken still links
      add_instr(6'h01, 6'h00, 5'h00, 0, 0, 1'b1, 1'b0);  // BLTZ taken
      add_instr(6'h2B, 6'h00, 5'h00, 1, 1, 1'b0, 1'b0);  //   SW in slot
      add_instr(6'h05, 6'h00, 5'h00, 0, 0, 1'b0, 1'b1);  // BNE not taken, zero target ignored
      add_instr(6'h03, 6'h00, 5'h00, 0, 0, 1'b0, 1'b0);  // JAL
      add_instr(6'h00, 6'h12, 5'h00, 0, 0, 1'b0, 1'b0);  //   MFLO in slot
      add_instr(6'h02, 6'h00, 5'h00, 0, 0, 1'b0, 1'b0);  // J
      add_instr(6'h09, 6'h00, 5'h00, 0, 0, 1'b0, 1'b0);  //   ADDIU in slot
      add_instr(6'h00, 6'h09, 5'h00, 0, 0, 1'b0, 1'b0);  // JALR
      add_instr(6'h26, 6'h00, 5'h00, 0, 0, 1'b0, 1'b0);  //   LWR in slot
      add_instr(6'h00, 6'h08, 5'h00, 0, 0, 1'b0, 1'b1);  // JR to address 0
      s = q_exp.size();
      add_instr(6'h00, 6'h00, 5'h00, 0, 0, 1'b0, 1'b0);  //   NOP in slot, then halt
      lit(s + 3, DSWB_V, "halt_slot_wb"); lit(s + 4, HALT_V, "halted");
      add_idle(4);
      add_reset();
      s = q_exp.size();
      add_instr(6'h00, 6'h21, 5'h00, WL, 0, 1'b0, 1'b0);  // fetch never accepted
      lit(s + WL - 1, FETCH_V, "last_tolerated_stall"); lit(s + WL, BERR_V, "fetch_timeout");
      add_idle(3);
      s = q_exp.size();
      add_reset();                                   lit(s, RST_V, "reset_clears_error");
      add_stall(3);
      s = q_exp.size();
      add_reset();                                   lit(s, RST_V, "async_reset_mid_stall");
      add_instr(6'h23, 6'h00, 5'h00, WL - 1, 0, 1'b0, 1'b0);  // counter restarted by reset
      s = q_exp.size();
      add_instr(6'h2B, 6'h00, 5'h00, 0, WL, 1'b0, 1'b0);  // store never accepted
      lit(s + 3, 15'b100100000000000, "store_mem"); lit(s + 3 + WL, BERR_V, "mem_timeout");
      add_idle(2);
      add_reset();
      add_instr(6'h00, 6'h21, 5'h00, 0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      build();
      fork
         begin
            for (int k = 0; k < q_exp.size(); k++) begin
               @(posedge clk);
               #1;
               reset          = ~q_rst[k];
               waitrequest    = q_wr[k];
               opcode         = q_op[k];
               funct          = q_fn[k];
               rt             = q_rt[k];
               branch_taken   = q_bt[k];
               target_is_zero = q_tz[k];
            end
         end
         begin
            for (int k = 0; k < q_exp.size(); k++) begin
               @(posedge clk);
               @(negedge clk);
               n_cmp++;
               if (dut_vec !== q_exp[k]) begin
                  n_bad++;
                  $display("FAIL cycle_%0d outputs: got %b required %b", k, dut_vec, q_exp[k]);
               end
               for (int j = 0; j < lit_idx.size(); j++) begin
                  if (lit_idx[j] == k) begin
                     n_cmp++;
                     if (dut_vec !== lit_vec[j]) begin
                        n_bad++;
                        $display("FAIL %s (cycle %0d): got %b required %b",
                                 lit_name[j], k, dut_vec, lit_vec[j]);
                     end
                  end
               end
            end
         end
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
